mux4x1_rr_arbiter: RTL
======================

Name: mux4x1_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 1-bit mux datapath among four requesters. It accepts one request line per source and registers a one-hot grant. It drives the mux selects s1/s2 from the granted owner and presents the selected input on out. A hold cap bounds how long one owner keeps the mux while others wait.

Parameters:
MAX_HOLD, 4, maximum consecutive granted cycles for one owner while another requester is pending (legal 1..15).

Ports:
clk    input   1  system clock, rising-edge
rst_n  input   1  reset; asynchronous, active-low
req    input   4  request per source; req[k] belongs to data input ik
i0     input   1  data from source 0
i1     input   1  data from source 1
i2     input   1  data from source 2
i3     input   1  data from source 3
gnt    output  4  registered one-hot grant; all-zero when idle
s1     output  1  mux select MSB = owner[1]
s2     output  1  mux select LSB = owner[0]
valid  output  1  high while a grant is active
out    output  1  selected data: i[owner] when valid, else 0

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-grant):
  - gnt=0, s1=0, s2=0, valid=0, out=0.
  - Internal: busy=0, owner=0, hold_cnt=0, last=3, so source 0 has first priority after reset.
- Select encoding:
  - i0 = {s1,s2}=00, i1 = 01, i2 = 10, i3 = 11.
  - out is a combinational mux of i0..i3 through the registered selects, gated by valid.
- rr_pick(mask): first set bit of mask, searching (last+1), (last+2), (last+3), last, all mod 4.
- State IDLE (busy=0):
  - At an edge with any req bit set: owner<=rr_pick(req), last<=owner chosen, gnt<=onehot(owner), busy<=1, hold_cnt<=0.
  - Latency: req high before edge N gives gnt/valid high after edge N (one clock).
- State GRANT (busy=1), evaluated each edge in this priority order:
  1. Release: req[owner]=0.
     - If other req bits are set: regrant rr_pick(req) with no idle bubble, hold_cnt<=0.
     - Otherwise go to IDLE: gnt<=0, valid<=0, s1/s2 keep their last values.
  2. Cap: req[owner]=1, hold_cnt==MAX_HOLD-1 and some other req bit set.
     - Regrant rr_pick(req & ~onehot(owner)), hold_cnt<=0.
  3. Hold: otherwise keep owner; hold_cnt increments, saturating at MAX_HOLD-1.
- Additional boundary rules:
  - A sole requester may hold indefinitely.
  - The cap applies only when another source is waiting.
  - With MAX_HOLD=1 the grant rotates every cycle among continuous requesters.
- last is updated on every new grant, so rotation order is fair: after owner k, search starts at k+1.
- gnt is always one-hot or zero; never multi-hot.
- valid == |gnt at all times.
- hold_cnt width is 4 bits.

Test Plan:
- Reset then req=0001 → after 1 edge: gnt=0001, s1s2=00, valid=1; with i0=1, out=1. Drop req → next edge gnt=0000, valid=0, out=0.
- req=1111 held constant, MAX_HOLD=4 → owners 0,1,2,3,0 in turn, each for exactly 4 cycles; s1s2 follow 00,01,10,11.
- Owner 2 holding, req=0100 only, for 20 cycles → gnt stays 0100 throughout (no cap without contention). Then raise req[0] → within 4 cycles of the raise, gnt=0001.
- Owner 1 drops req on the same edge that req[3] rises (req 0010→1000) → next grant is 1000 with no idle cycle; out tracks i3.
- Assert rst_n=0 mid-grant between clock edges → gnt, valid, s1, s2 and out go to 0 without a clock edge. After release with req=1010 → first grant goes to source 1 (search starts at 0).
- For all 16 combinations of i0..i3, force each owner in turn → out equals i[owner]. Check gnt is one-hot or zero on every cycle.

Source files
------------

// File: rtl/mux4x1_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4x1_rr_arbiter
//
// Round-robin arbiter in front of a shared 4:1 one-bit mux. Four sources raise
// request lines; one owner at a time is granted the mux. The grant is held
// while the owner keeps requesting. When other sources are waiting, the hold
// is capped at MAX_HOLD consecutive cycles. After that the next source in
// rotation order takes over.
//
// Parameters:
//   MAX_HOLD  maximum consecutive granted cycles for one owner while another
//             source is pending (1..15; hold_cnt is 4 bits wide)
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   4  request per source, req[k] belongs to data input ik
//   i0..i3 in   1  data from sources 0..3
//   gnt    out  4  registered one-hot grant, all-zero when idle
//   s1     out  1  mux select MSB (owner[1])
//   s2     out  1  mux select LSB (owner[0])
//   valid  out  1  high while a grant is active (== |gnt)
//   out    out  1  i[owner] while valid, else 0
//
// Handshake: a source holds req[k] high for as long as it wants the mux. It
// owns the mux in every cycle where gnt[k] is high. Dropping req[k] releases
// the grant at the next edge. There is no separate acknowledge.
// -----------------------------------------------------------------------------
module mux4x1_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       i0,
    input  logic       i1,
    input  logic       i2,
    input  logic       i3,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s2,
    output logic       valid,
    output logic       out
);

    // Last hold cycle before the cap can fire.
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] owner;
    logic [1:0] last;
    logic [3:0] hold_cnt;

    // Combinational helpers for the state update.
    logic [3:0] owner_oh;
    logic [3:0] others;
    logic [1:0] pick_any;
    logic [1:0] pick_other;
    logic       owner_req;
    logic       others_pending;
    logic       mux_bit;

    // Returns the first set bit of mask, searching from from+1 upward and
    // wrapping mod 4. The last position examined is from itself. When mask
    // is empty the result is from. Callers only use the result when mask
    // is non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] from);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = from;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = from + 2'(k);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    always_comb begin
        owner_oh       = onehot(owner);
        others         = req & ~owner_oh;
        owner_req      = |(req & owner_oh);
        others_pending = |others;
        pick_any       = rr_pick(req, last);
        pick_other     = rr_pick(others, last);
    end

    // Single state machine. All outputs except out/valid are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 2'd0;
            last     <= 2'd3;       // source 0 is searched first after reset
            hold_cnt <= 4'd0;
            gnt      <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= GRANT;
                        owner    <= pick_any;
                        last     <= pick_any;
                        gnt      <= onehot(pick_any);
                        hold_cnt <= 4'd0;
                    end
                end

                GRANT: begin
                    if (!owner_req) begin
                        // Owner released. Hand over directly if someone else
                        // is waiting, so no idle bubble is inserted.
                        if (others_pending) begin
                            owner    <= pick_any;
                            last     <= pick_any;
                            gnt      <= onehot(pick_any);
                            hold_cnt <= 4'd0;
                        end else begin
                            // owner is kept, so s1/s2 hold their last values.
                            state    <= IDLE;
                            gnt      <= 4'b0000;
                            hold_cnt <= 4'd0;
                        end
                    end else if (hold_cnt == HOLD_LAST && others_pending) begin
                        // Cap reached with contention: force rotation away
                        // from the current owner.
                        owner    <= pick_other;
                        last     <= pick_other;
                        gnt      <= onehot(pick_other);
                        hold_cnt <= 4'd0;
                    end else begin
                        // Keep the owner. The counter saturates, so a sole
                        // requester holds indefinitely. The cap then fires
                        // on the first edge where a competitor appears.
                        if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    gnt   <= 4'b0000;
                end
            endcase
        end
    end

    assign s1    = owner[1];
    assign s2    = owner[0];
    assign valid = |gnt;

    // Shared datapath: a 4:1 mux steered by the registered selects.
    always_comb begin
        case ({s1, s2})
            2'b00:   mux_bit = i0;
            2'b01:   mux_bit = i1;
            2'b10:   mux_bit = i2;
            default: mux_bit = i3;
        endcase
    end

    assign out = valid ? mux_bit : 1'b0;

endmodule
